add_accumulator: RTL and testbench

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_accumulator.sv | 125 ++++++++++++
 tb/tb_add_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accumulator.sv
// Streaming signed accumulator. Sums the beats of a frame with saturation at every
// step and presents the sum, a sticky saturation flag and a beat count at the frame end.

module CarryLookAheadAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Overflow
);
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    // NOTE: every variable written in always_comb gets a value before any branch or
    // loop can skip it; a path that leaves it untouched would infer a latch.
    always_comb begin
        gen   = A & B;
        prop  = A ^ B;
        carry = '0;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign Sum      = prop ^ carry[N-1:0];
    assign Cout     = carry[N];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign Overflow = carry[N] ^ carry[N-1];
endmodule

module add_accumulator #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_sat,
    output logic [CW-1:0] out_count
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t        state;
    logic [N-1:0]  acc;
    logic          sat;
    logic [CW-1:0] count;

    logic [N-1:0]  operand;
    logic [N-1:0]  sum;
    logic [N-1:0]  sat_result;
    logic          overflow;
    logic          unused_cout;
    logic          accept;

    assign in_ready = rst_n & ~clear & (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign operand  = (state == IDLE) ? '0 : acc;

    CarryLookAheadAdder #(.N(N)) u_adder (
        .A        (operand),
        .B        (in_data),
        .Sum      (sum),
        .Cout     (unused_cout),
        .Overflow (overflow)
    );

    // Overflow can only go in the direction of the addend's sign.
    always_comb begin
        sat_result = sum;
        if (overflow) begin
            sat_result = in_data[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= sat_result;
                        sat   <= sat | overflow;
                        if (count != '1) count <= count + 1'b1;
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        sat   <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The frame registers only change on accepted beats, so in HOLD they are stable.
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_sat   = sat;
    assign out_count = count;
endmodule

// File: tb/tb_add_accumulator.sv
// Randomized scoreboard bench for add_accumulator (N=8, CW=4) with directed corner frames
// and an arithmetic reference model of the saturating frame sum.

module tb_add_accumulator;
    localparam int N     = 8;
    localparam int CW    = 4;
    localparam int MAXP  = 2 ** (N - 1) - 1;
    localparam int MINN  = -(2 ** (N - 1));
    localparam int MAXC  = 2 ** CW - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_sat;
    logic [CW-1:0] out_count;

    add_accumulator #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  data;
        logic          sat;
        logic [CW-1:0] count;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   beats[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: running sum clamped to the signed range after every beat.
    function automatic exp_t model();
        exp_t e;
        int   s = 0;
        e.sat = 1'b0;
        foreach (beats[i]) begin
            s += beats[i];
            if (s > MAXP) begin
                s = MAXP;
                e.sat = 1'b1;
            end else if (s < MINN) begin
                s = MINN;
                e.sat = 1'b1;
            end
        end
        e.data  = N'(s);
        e.count = CW'((beats.size() > MAXC) ? MAXC : beats.size());
        e.cyc   = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per presented result, then checks stability in HOLD.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_valid) begin
                        check("result_expected", exp_q.size(), 1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            check("result_latency", cyc, cur.cyc);
                        end
                    end
                    check("out_data", out_data, cur.data);
                    check("out_sat", out_sat, cur.sat);
                    check("out_count", out_count, cur.count);
                    check("in_ready_hold", in_ready, 0);
                end else if (!clear) begin
                    check("in_ready_open", in_ready, 1);
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic send_beat(input int v, input bit last);
        bit ok = 1'b0;
        int gap = $urandom_range(0, 2);
        exp_t e;
        repeat (gap) begin
            in_valid  = 1'b0;
            in_data   = N'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b1;
        in_data   = N'(v);
        in_last   = last;
        out_ready = 1'($urandom);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("beat_accepted", ok, 1);
        if (ok && last) begin
            e = model();
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) out_ready = 1'b0;
    endtask

    task automatic send_frame(input int hold, input bit valid_in_hold);
        bit ok = 1'b0;
        foreach (beats[i]) send_beat(beats[i], (i == beats.size() - 1));
        if (valid_in_hold) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            in_last  = 1'($urandom);
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("handshake_seen", ok, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_sat"}, out_sat, 0);
        check({tag, "_out_count"}, out_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sum, positive and negative saturation, saturate-then-continue.
        beats = '{10, 20, -5};        send_frame(0, 1'b0);
        beats = '{100, 100};          send_frame(1, 1'b0);
        beats = '{-100, -100};        send_frame(2, 1'b0);
        beats = '{100, 100, -50};     send_frame(0, 1'b0);

        // Long hold with a beat waiting, then the next frame must start from zero.
        beats = '{3, 4};              send_frame(5, 1'b1);
        beats = '{1};                 send_frame(0, 1'b0);

        // Abort mid-frame; the beat offered during clear is not taken.
        send_beat(40, 1'b0);
        send_beat(50, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = N'(55); in_last = 1'b1;
        @(negedge clk);
        check("clear_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        beats = '{7};                 send_frame(0, 1'b0);

        // Clear while a result is presented discards it without a handshake.
        beats = '{5, 6};
        foreach (beats[i]) send_beat(beats[i], (i == beats.size() - 1));
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        check_zero_outputs("clear_hold");
        beats = '{2};                 send_frame(1, 1'b0);

        // Beat counter saturation.
        beats.delete();
        repeat (18) beats.push_back(1);
        send_frame(0, 1'b0);

        // Reset in the middle of a frame.
        send_beat(9, 1'b0);
        send_beat(9, 1'b0);
        send_beat(9, 1'b0);
        rst_n = 1'b0; in_valid = 1'b1; in_data = N'(9);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check_zero_outputs("mid_reset");
        rst_n = 1'b1; in_valid = 1'b0;
        beats = '{4};                 send_frame(0, 1'b0);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            int len = $urandom_range(1, 6);
            beats.delete();
            for (int b = 0; b < len; b++) beats.push_back(int'($urandom_range(0, 255)) - 128);
            send_frame($urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
